v_writeback: RTL and testbench

Vector writeback stage sitting between the combinational vector ALU execute stage and the vector register file (VRF) write port. Accepts one full-width ALU result per valid/ready handshake, buffers up to `DEPTH` results, and drains each into the VRF as `VREG_W/BEAT_W` sequential beats over a narrower write port. Reduction results write beat 0 only. Also publishes a read-after-write hazard stall for the issue logic.

---
 rtl/v_writeback_pkg.sv | 17 +
 rtl/v_wb_fifo.sv | 79 +++++++
 rtl/v_writeback.sv | 158 +++++++++++++++
 tb/tb_v_writeback.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_writeback_pkg.sv
// Shared constants and types for the vector writeback stage.
//   VWB_VREG_W  : vector register / ALU result width in bits
//   VWB_BEAT_W  : VRF write-port width in bits
//   VWB_DEPTH   : number of buffered results (power of two, >= 2)
//   wb_state_e  : drain FSM encoding (IDLE = 1'b0, WRITE = 1'b1)
package v_writeback_pkg;

   localparam int VWB_VREG_W = 256;
   localparam int VWB_BEAT_W = 64;
   localparam int VWB_DEPTH  = 2;

   typedef enum logic {
      VWB_IDLE  = 1'b0,
      VWB_WRITE = 1'b1
   } wb_state_e;

endpackage

// File: rtl/v_wb_fifo.sv
// Circular buffer of writeback entries ({vd, red, result} packed by the caller).
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   i_push / i_wdata : write one entry at the tail (ignored during flush)
//   i_pop            : retire the head entry
//   i_flush          : discard every entry except a started head
//   i_keep_head      : the head has started draining and must survive a flush
//   o_head           : head entry
//   o_count, o_full, o_empty : occupancy
//   o_slot_vld / o_slots     : per-slot valid flags and raw contents (hazard compare)
module v_wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [W-1:0]       i_wdata,
   input  logic               i_pop,
   input  logic               i_flush,
   input  logic               i_keep_head,
   output logic [W-1:0]       o_head,
   output logic [CW-1:0]      o_count,
   output logic               o_full,
   output logic               o_empty,
   output logic [DEPTH-1:0]   o_slot_vld,
   output logic [DEPTH*W-1:0] o_slots
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [PW-1:0] w_rptr_n;
   logic          w_keep;

   assign w_rptr_n = r_rptr + PW'(i_pop);
   // A head that retires this cycle is gone even if it had started.
   assign w_keep   = i_keep_head && !i_pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_rptr <= w_rptr_n;
         if (i_flush) begin
            r_wptr  <= w_rptr_n + PW'(w_keep);
            r_count <= CW'(w_keep);
         end else begin
            if (i_push) r_wptr <= r_wptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
         end
      end
   end

   // Storage needs no reset: only slots covered by count are ever read as valid.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wptr] <= i_wdata;
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic [PW-1:0] w_off;
      // Distance of this slot from the head, modulo DEPTH.
      assign w_off                = PW'(g) - r_rptr;
      assign o_slot_vld[g]        = ({1'b0, w_off} < r_count);
      assign o_slots[g*W +: W]    = r_mem[g];
   end

endmodule

// File: rtl/v_writeback.sv
// Vector writeback stage: buffers full-width ALU results and drains each into
// the VRF as BEATS sequential narrow beats (reductions write beat 0 only).
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   ex_valid_i/ex_ready_o             : result handshake from execute
//   ex_result_i, ex_vd_i, ex_red_i    : result, destination, reduction flag
//   flush_i                           : drop all entries that have not started
//   vrf_wen_o/vrf_ready_i             : beat handshake to the VRF
//   vrf_addr_o, vrf_beat_o, vrf_wdata_o : beat destination, index and data
//   done_o                            : pulse the cycle after an entry's last beat
//   hz_vs1_i, hz_vs2_i, hz_stall_o    : read-after-write hazard check for issue
//   dbg_state_o                       : drain FSM state
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid && !ready, and ready never
// depends on valid on the same interface.
module v_writeback
   import v_writeback_pkg::*;
#(
   parameter int VREG_W = VWB_VREG_W,
   parameter int BEAT_W = VWB_BEAT_W,
   parameter int DEPTH  = VWB_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic [VREG_W-1:0] ex_result_i,
   input  logic [4:0]        ex_vd_i,
   input  logic              ex_red_i,
   input  logic              flush_i,
   output logic              vrf_wen_o,
   input  logic              vrf_ready_i,
   output logic [4:0]        vrf_addr_o,
   output logic [((VREG_W/BEAT_W) > 1 ? $clog2(VREG_W/BEAT_W) : 1)-1:0] vrf_beat_o,
   output logic [BEAT_W-1:0] vrf_wdata_o,
   output logic              done_o,
   input  logic [4:0]        hz_vs1_i,
   input  logic [4:0]        hz_vs2_i,
   output logic              hz_stall_o,
   output logic              dbg_state_o
);

   localparam int BEATS = VREG_W / BEAT_W;
   localparam int BIW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int EW    = VREG_W + 6;
   localparam int CW    = $clog2(DEPTH) + 1;

   wb_state_e          r_state;
   wb_state_e          w_state_n;
   logic [BIW-1:0]     r_beat_cnt;
   logic               r_done;

   logic               w_push;
   logic               w_accept;
   logic               w_last;
   logic               w_pop;
   logic               w_keep;
   logic               w_full;
   logic               w_empty;
   logic [CW-1:0]      w_count;
   logic [CW-1:0]      w_count_n;
   logic [EW-1:0]      w_head;
   logic [DEPTH-1:0]   w_slot_vld;
   logic [DEPTH*EW-1:0] w_slots;
   logic [4:0]         w_head_vd;
   logic               w_head_red;
   logic [VREG_W-1:0]  w_head_res;
   logic               w_hz;

   v_wb_fifo #(.DEPTH(DEPTH), .W(EW), .CW(CW)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_wdata     ({ex_vd_i, ex_red_i, ex_result_i}),
      .i_pop       (w_pop),
      .i_flush     (flush_i),
      .i_keep_head (w_keep),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_slot_vld  (w_slot_vld),
      .o_slots     (w_slots)
   );

   assign w_head_vd  = w_head[EW-1 -: 5];
   assign w_head_red = w_head[VREG_W];
   assign w_head_res = w_head[VREG_W-1:0];

   assign ex_ready_o = !w_full;
   // A push coinciding with a flush is dropped.
   assign w_push     = ex_valid_i && ex_ready_o && !flush_i;
   assign w_accept   = (r_state == VWB_WRITE) && vrf_ready_i;
   assign w_last     = w_head_red || (r_beat_cnt == BIW'(BEATS - 1));
   assign w_pop      = w_accept && w_last;
   // The head has started once any beat is accepted (now or earlier).
   assign w_keep     = (r_state == VWB_WRITE) && ((r_beat_cnt != '0) || w_accept);

   // Occupancy after this edge; drives the IDLE/WRITE decision.
   always_comb begin
      if (flush_i) w_count_n = (w_keep && !w_pop) ? CW'(1) : '0;
      else         w_count_n = w_count + CW'(w_push) - CW'(w_pop);
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= VWB_IDLE;
         r_beat_cnt <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_done  <= w_pop;
         if (w_accept) r_beat_cnt <= w_last ? '0 : r_beat_cnt + BIW'(1);
      end
   end

   // FSM: next state
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         VWB_IDLE:  if (w_count_n != '0) w_state_n = VWB_WRITE;
         VWB_WRITE: if (w_count_n == '0) w_state_n = VWB_IDLE;
         default:   w_state_n = VWB_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      vrf_wen_o   = 1'b0;
      vrf_addr_o  = '0;
      vrf_beat_o  = '0;
      vrf_wdata_o = '0;
      if (r_state == VWB_WRITE && !w_empty) begin
         vrf_wen_o   = 1'b1;
         vrf_addr_o  = w_head_vd;
         vrf_beat_o  = r_beat_cnt;
         vrf_wdata_o = w_head_res[int'(r_beat_cnt)*BEAT_W +: BEAT_W];
      end
   end

   // Hazard: any buffered destination or the destination being pushed now.
   always_comb begin
      w_hz = ex_valid_i && ex_ready_o &&
             ((ex_vd_i == hz_vs1_i) || (ex_vd_i == hz_vs2_i));
      for (int i = 0; i < DEPTH; i++) begin
         if (w_slot_vld[i] &&
             ((w_slots[i*EW + VREG_W + 1 +: 5] == hz_vs1_i) ||
              (w_slots[i*EW + VREG_W + 1 +: 5] == hz_vs2_i)))
            w_hz = 1'b1;
      end
   end

   assign hz_stall_o  = w_hz;
   assign done_o      = r_done;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_v_writeback.sv
module tb_v_writeback;

   localparam int VW    = 256;
   localparam int BW    = 64;
   localparam int DEPTH = 2;
   localparam int BEATS = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_valid_i;
   logic          ex_ready_o;
   logic [VW-1:0] ex_result_i;
   logic [4:0]    ex_vd_i;
   logic          ex_red_i;
   logic          flush_i;
   logic          vrf_wen_o;
   logic          vrf_ready_i;
   logic [4:0]    vrf_addr_o;
   logic [1:0]    vrf_beat_o;
   logic [BW-1:0] vrf_wdata_o;
   logic          done_o;
   logic [4:0]    hz_vs1_i;
   logic [4:0]    hz_vs2_i;
   logic          hz_stall_o;
   logic          dbg_state_o;

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   v_writeback dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid_i  (ex_valid_i),
      .ex_ready_o  (ex_ready_o),
      .ex_result_i (ex_result_i),
      .ex_vd_i     (ex_vd_i),
      .ex_red_i    (ex_red_i),
      .flush_i     (flush_i),
      .vrf_wen_o   (vrf_wen_o),
      .vrf_ready_i (vrf_ready_i),
      .vrf_addr_o  (vrf_addr_o),
      .vrf_beat_o  (vrf_beat_o),
      .vrf_wdata_o (vrf_wdata_o),
      .done_o      (done_o),
      .hz_vs1_i    (hz_vs1_i),
      .hz_vs2_i    (hz_vs2_i),
      .hz_stall_o  (hz_stall_o),
      .dbg_state_o (dbg_state_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + compare ----------------
   typedef struct packed {
      logic [4:0]    vd;
      logic          red;
      logic [VW-1:0] res;
   } ent_t;

   ent_t          mq[$];
   ent_t          m_new;
   int            m_beat = 0;
   bit            m_done = 0;
   logic          e_wen, e_ready, e_hz;
   logic [4:0]    e_addr;
   logic [1:0]    e_beat;
   logic [BW-1:0] e_data;
   bit            acc, last, started;

   always @(negedge clk) begin
      if (!rst) begin
         mq.delete();
         m_beat = 0;
         m_done = 0;
         chk("rst_wen", 64'(vrf_wen_o), 64'd0);
         chk("rst_ready", 64'(ex_ready_o), 64'd1);
         chk("rst_done", 64'(done_o), 64'd0);
      end else begin
         e_wen   = (mq.size() != 0);
         e_addr  = '0;
         e_beat  = '0;
         e_data  = '0;
         if (e_wen) begin
            e_addr = mq[0].vd;
            e_beat = 2'(m_beat);
            e_data = mq[0].res[m_beat*BW +: BW];
         end
         e_ready = (mq.size() < DEPTH);
         e_hz    = ex_valid_i && e_ready && (ex_vd_i == hz_vs1_i || ex_vd_i == hz_vs2_i);
         foreach (mq[i]) if (mq[i].vd == hz_vs1_i || mq[i].vd == hz_vs2_i) e_hz = 1'b1;

         chk("m_wen",   64'(vrf_wen_o),   64'(e_wen));
         chk("m_addr",  64'(vrf_addr_o),  64'(e_addr));
         chk("m_beat",  64'(vrf_beat_o),  64'(e_beat));
         chk("m_data",  vrf_wdata_o,      e_data);
         chk("m_ready", 64'(ex_ready_o),  64'(e_ready));
         chk("m_done",  64'(done_o),      64'(m_done));
         chk("m_hz",    64'(hz_stall_o),  64'(e_hz));

         // advance the model by the edge that follows
         acc     = e_wen && vrf_ready_i;
         last    = acc && (mq[0].red || m_beat == BEATS - 1);
         started = e_wen && (m_beat != 0 || acc);
         if (last) begin
            void'(mq.pop_front());
            m_beat = 0;
         end else if (acc) begin
            m_beat++;
         end
         if (flush_i) begin
            if (started && !last) begin
               while (mq.size() > 1) void'(mq.pop_back());
            end else begin
               mq.delete();
               m_beat = 0;
            end
         end else if (ex_valid_i && e_ready) begin
            m_new.vd  = ex_vd_i;
            m_new.red = ex_red_i;
            m_new.res = ex_result_i;
            mq.push_back(m_new);
         end
         m_done = last;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_result(output logic [VW-1:0] r);
      for (int i = 0; i < VW/32; i++) r[i*32 +: 32] = $urandom;
   endtask

   task automatic push_set(input logic [4:0] vd, input logic red, input logic [VW-1:0] res);
      ex_valid_i  = 1'b1;
      ex_vd_i     = vd;
      ex_red_i    = red;
      ex_result_i = res;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit            pushed;
      logic [VW-1:0] r;

      rst = 1'b0;
      ex_valid_i = 0; ex_result_i = '0; ex_vd_i = '0; ex_red_i = 0;
      flush_i = 0; vrf_ready_i = 0; hz_vs1_i = '0; hz_vs2_i = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_wen",   64'(vrf_wen_o),   64'd0);
      chk("reset_addr",  64'(vrf_addr_o),  64'd0);
      chk("reset_beat",  64'(vrf_beat_o),  64'd0);
      chk("reset_wdata", vrf_wdata_o,      64'd0);
      chk("reset_ready", 64'(ex_ready_o),  64'd1);
      chk("reset_done",  64'(done_o),      64'd0);
      chk("reset_hz",    64'(hz_stall_o),  64'd0);
      tick();
      rst = 1'b1;

      // single full entry
      tick();
      vrf_ready_i = 1'b1;
      push_set(5'd3, 1'b0, {64'h4, 64'h3, 64'h2, 64'h1});
      tick();
      ex_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("se_wen",  64'(vrf_wen_o),  64'd1);
         chk("se_addr", 64'(vrf_addr_o), 64'd3);
         chk("se_beat", 64'(vrf_beat_o), 64'(k));
         chk("se_data", vrf_wdata_o,     64'(k + 1));
         tick();
      end
      @(negedge clk);
      chk("se_done", 64'(done_o),    64'd1);
      chk("se_idle", 64'(vrf_wen_o), 64'd0);
      tick();

      // backpressure at beat 2
      push_set(5'd4, 1'b0, {64'hD3, 64'hD2, 64'hD1, 64'hD0});
      tick();
      ex_valid_i = 1'b0;
      tick();
      tick();
      vrf_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_beat", 64'(vrf_beat_o), 64'd2);
         chk("bp_data", vrf_wdata_o,     64'hD2);
         tick();
      end
      vrf_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_beat2", 64'(vrf_beat_o), 64'd2);
      tick();
      @(negedge clk);
      chk("bp_beat3", 64'(vrf_beat_o), 64'd3);
      chk("bp_data3", vrf_wdata_o,     64'hD3);
      tick();
      @(negedge clk);
      chk("bp_done", 64'(done_o), 64'd1);
      tick();

      // full buffer, then drain with no gaps
      vrf_ready_i = 1'b0;
      rand_result(r);
      push_set(5'd1, 1'b0, r);
      tick();
      rand_result(r);
      push_set(5'd2, 1'b0, r);
      tick();
      rand_result(r);
      push_set(5'd3, 1'b0, r);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("fb_ready", 64'(ex_ready_o), 64'd0);
         tick();
      end
      vrf_ready_i = 1'b1;
      pushed = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("fb_wen",  64'(vrf_wen_o),  64'd1);
         chk("fb_addr", 64'(vrf_addr_o), (k < 4) ? 64'd1 : 64'd2);
         chk("fb_beat", 64'(vrf_beat_o), 64'(k % 4));
         if (!pushed && ex_ready_o) pushed = 1'b1;
         tick();
         if (pushed) ex_valid_i = 1'b0;
      end
      chk("fb_push3", 64'(pushed), 64'd1);
      @(negedge clk);
      chk("fb_addr3", 64'(vrf_addr_o), 64'd3);
      chk("fb_wen3",  64'(vrf_wen_o),  64'd1);
      repeat (6) tick();

      // reduction
      push_set(5'd7, 1'b1, 256'h55);
      tick();
      ex_valid_i = 1'b0;
      ex_red_i   = 1'b0;
      @(negedge clk);
      chk("red_wen",  64'(vrf_wen_o),  64'd1);
      chk("red_addr", 64'(vrf_addr_o), 64'd7);
      chk("red_beat", 64'(vrf_beat_o), 64'd0);
      chk("red_data", vrf_wdata_o,     64'h55);
      tick();
      @(negedge clk);
      chk("red_done", 64'(done_o),    64'd1);
      chk("red_idle", 64'(vrf_wen_o), 64'd0);
      tick();

      // hazard and flush
      hz_vs1_i = 5'd20;
      rand_result(r);
      push_set(5'd5, 1'b0, r);
      tick();
      rand_result(r);
      push_set(5'd9, 1'b0, r);
      tick();
      ex_valid_i = 1'b0;
      hz_vs2_i   = 5'd9;
      @(negedge clk);
      chk("hf_hz1",  64'(hz_stall_o), 64'd1);
      chk("hf_beat", 64'(vrf_beat_o), 64'd1);
      tick();
      flush_i = 1'b1;
      @(negedge clk);
      chk("hf_beat2", 64'(vrf_beat_o), 64'd2);
      tick();
      flush_i = 1'b0;
      @(negedge clk);
      chk("hf_beat3", 64'(vrf_beat_o), 64'd3);
      chk("hf_addr3", 64'(vrf_addr_o), 64'd5);
      chk("hf_hz0",   64'(hz_stall_o), 64'd0);
      tick();
      @(negedge clk);
      chk("hf_done", 64'(done_o),    64'd1);
      chk("hf_idle", 64'(vrf_wen_o), 64'd0);
      tick();
      @(negedge clk);
      chk("hf_drop", 64'(vrf_wen_o), 64'd0);
      tick();

      // asynchronous reset mid-write
      hz_vs1_i = '0;
      hz_vs2_i = '0;
      rand_result(r);
      push_set(5'd6, 1'b0, r);
      tick();
      ex_valid_i = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("ar_wen",   64'(vrf_wen_o),  64'd0);
      chk("ar_ready", 64'(ex_ready_o), 64'd1);
      chk("ar_addr",  64'(vrf_addr_o), 64'd0);
      tick();
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("ar_quiet", 64'(vrf_wen_o), 64'd0);
         tick();
      end

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         ex_valid_i  = ($urandom_range(0, 9) < 6);
         ex_vd_i     = 5'($urandom_range(0, 7));
         ex_red_i    = ($urandom_range(0, 3) == 0);
         rand_result(r);
         ex_result_i = r;
         vrf_ready_i = ($urandom_range(0, 9) < 7);
         flush_i     = ($urandom_range(0, 24) == 0);
         hz_vs1_i    = 5'($urandom_range(0, 7));
         hz_vs2_i    = 5'($urandom_range(0, 7));
         tick();
      end
      ex_valid_i  = 1'b0;
      flush_i     = 1'b0;
      vrf_ready_i = 1'b1;
      repeat (12) tick();
      @(negedge clk);
      chk("end_idle", 64'(vrf_wen_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
